i2s_rx_sched: RTL and testbench

Sample scheduler and buffer that sits between the I2S receiver (`i2s_rx`) and the AHB-Lite slave wrapper. It detects frame boundaries from the receiver's word-select output and captures the 64-bit stereo word. It applies mono/stereo selection, frame decimation and optional sign extension, then queues 32-bit samples in a first-word-fall-through (FWFT) FIFO. Level, overflow and threshold-interrupt status go to the bus side.

---
 rtl/i2s_rx_sched_if.sv | 32 +++
 rtl/i2s_rx_sched.sv | 218 +++++++++++++++++++++
 tb/tb_i2s_rx_sched.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_sched_if.sv
// Bus-side bundle of the I2S receive scheduler: configuration, FIFO pop port and status.
// The master is the AHB-Lite slave wrapper and the slave is i2s_rx_sched.
interface i2s_rx_sched_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          en;
    logic          stereo;
    logic          sign_ext;
    logic [3:0]    decim;
    logic [AW:0]   thresh;
    logic          flush;
    logic          ovf_clr;
    logic          rd;
    logic [31:0]   rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          ovf;
    logic          irq;

    modport master (
        output en, stereo, sign_ext, decim, thresh, flush, ovf_clr, rd,
        input  rd_data, empty, full, level, ovf, irq
    );

    modport slave (
        input  en, stereo, sign_ext, decim, thresh, flush, ovf_clr, rd,
        output rd_data, empty, full, level, ovf, irq
    );
endinterface

// File: rtl/i2s_rx_sched.sv
// Frame-synchronous sample scheduler between i2s_rx and the bus wrapper: frame detect,
// mono/stereo selection, decimation, sign extension and a FWFT sample FIFO with status.
module i2s_rx_sched #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ws,
    input  logic [63:0]  rx_data,
    i2s_rx_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_PUSH_R = 2'd3;

    function automatic logic [31:0] fmt_sample(input logic [23:0] raw, input logic sx);
        logic [31:0] res;
        if (sx) begin
            res = {{8{raw[23]}}, raw};
        end else begin
            res = {8'h00, raw};
        end
        return res;
    endfunction

    logic          ws_q1_r;
    logic          ws_q2_r;
    logic [1:0]    state_r;
    logic [3:0]    dcnt_r;
    logic [31:0]   hold_r;
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [31:0]   mem_r [DEPTH];
    logic [31:0]   rd_data_r;
    logic          empty_r;
    logic          full_r;
    logic [AW:0]   level_r;
    logic          ovf_r;
    logic          irq_r;

    logic          frame_s;
    logic [31:0]   left_s;
    logic [31:0]   right_s;
    logic          unused_rx_s;
    logic [1:0]    state_nxt_s;
    logic [3:0]    dcnt_nxt_s;
    logic [31:0]   hold_nxt_s;
    logic          push_s;
    logic [31:0]   wdata_s;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [AW:0]   wr_nxt_s;
    logic [AW:0]   rd_nxt_s;
    logic [AW:0]   level_nxt_s;
    logic [31:0]   head_s;
    logic [31:0]   rd_data_nxt_s;
    logic          full_nxt_s;
    logic          irq_nxt_s;
    logic          ovf_nxt_s;

    assign frame_s     = ws_q1_r & ~ws_q2_r;
    assign left_s      = fmt_sample(rx_data[55:32], bus.sign_ext);
    assign right_s     = fmt_sample(rx_data[23:0], bus.sign_ext);
    assign unused_rx_s = ^{rx_data[63:56], rx_data[31:24]};

    // Capture state machine: decides when a sample is pushed and which one.
    always_comb begin
        state_nxt_s = state_r;
        dcnt_nxt_s  = dcnt_r;
        hold_nxt_s  = hold_r;
        push_s      = 1'b0;
        wdata_s     = left_s;
        if (!bus.en) begin
            state_nxt_s = ST_IDLE;
            dcnt_nxt_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ARM;
                    dcnt_nxt_s  = 4'd0;
                end
                ST_ARM: begin
                    // Preloading decim makes the first frame after the discarded one a kept frame.
                    if (frame_s) begin
                        state_nxt_s = ST_RUN;
                        dcnt_nxt_s  = bus.decim;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_RUN: begin
                    // >= rather than == so a decim lowered mid-run cannot strand the counter.
                    if (frame_s && (dcnt_r >= bus.decim)) begin
                        push_s     = 1'b1;
                        dcnt_nxt_s = 4'd0;
                        if (bus.stereo) begin
                            hold_nxt_s  = right_s;
                            state_nxt_s = ST_PUSH_R;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else if (frame_s) begin
                        dcnt_nxt_s = dcnt_r + 4'd1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PUSH_R: begin
                    push_s      = 1'b1;
                    wdata_s     = hold_r;
                    state_nxt_s = ST_RUN;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    dcnt_nxt_s  = 4'd0;
                end
            endcase
        end
    end

    // FIFO pointer arithmetic: pop first, push may reuse the freed slot, flush wins over both.
    always_comb begin
        empty_s  = (wr_ptr_r == rd_ptr_r);
        full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s    = bus.rd & ~empty_s & ~bus.flush;
        wr_en_s  = push_s & (~full_s | pop_s) & ~bus.flush;
        drop_s   = push_s & full_s & ~pop_s & ~bus.flush;
        if (bus.flush) begin
            wr_nxt_s = {(AW+1){1'b0}};
            rd_nxt_s = {(AW+1){1'b0}};
        end else begin
            wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
            rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        end
        level_nxt_s = wr_nxt_s - rd_nxt_s;
        full_nxt_s  = (wr_nxt_s[AW] != rd_nxt_s[AW]) && (wr_nxt_s[AW-1:0] == rd_nxt_s[AW-1:0]);
        // The slot being written this edge is only the new head when the FIFO drained to it.
        if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_nxt_s[AW-1:0])) begin
            head_s = wdata_s;
        end else begin
            head_s = mem_r[rd_nxt_s[AW-1:0]];
        end
        if (level_nxt_s == {(AW+1){1'b0}}) begin
            rd_data_nxt_s = 32'h0000_0000;
        end else begin
            rd_data_nxt_s = head_s;
        end
        irq_nxt_s = (bus.thresh != {(AW+1){1'b0}}) && (level_nxt_s >= bus.thresh);
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Word-select synchroniser and capture state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q1_r <= 1'b1;
            ws_q2_r <= 1'b1;
            state_r <= ST_IDLE;
            dcnt_r  <= 4'd0;
            hold_r  <= 32'h0000_0000;
        end else begin
            ws_q1_r <= ws;
            ws_q2_r <= ws_q1_r;
            state_r <= state_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // FIFO pointers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
            rd_data_r <= 32'h0000_0000;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            level_r   <= {(AW+1){1'b0}};
            ovf_r     <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_nxt_s;
            rd_ptr_r  <= rd_nxt_s;
            rd_data_r <= rd_data_nxt_s;
            empty_r   <= (level_nxt_s == {(AW+1){1'b0}});
            full_r    <= full_nxt_s;
            level_r   <= level_nxt_s;
            ovf_r     <= ovf_nxt_s;
            irq_r     <= irq_nxt_s;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata_s;
        end
    end

    assign bus.rd_data = rd_data_r;
    assign bus.empty   = empty_r;
    assign bus.full    = full_r;
    assign bus.level   = level_r;
    assign bus.ovf     = ovf_r;
    assign bus.irq     = irq_r;
endmodule

// File: tb/tb_i2s_rx_sched.sv
// Scenario bench for i2s_rx_sched: expected samples are queued as frames are driven
// and popped as the FIFO is drained.
module tb_i2s_rx_sched;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws = 1'b0;
    logic [63:0] rx_data = 64'h0;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_q[$];

    i2s_rx_sched_if #(.DEPTH(DEPTH)) bus ();

    i2s_rx_sched #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ws      (ws),
        .rx_data (rx_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Low half of a frame, then ws rises with the new word; caller times the rest.
    task automatic frame_open(input logic [31:0] l, input logic [31:0] r);
        ws = 1'b0;
        repeat (4) tick();
        rx_data = {l, r};
        ws = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
        frame_open(l, r);
        repeat (4) tick();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 4 && exp_q.size() > 0; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (bus.empty !== 1'b0 || bus.rd_data !== e)
                $display("FAIL %s_data got=%h empty=%b expected=%h", tag, bus.rd_data, bus.empty, e);
            else passed++;
            bus.rd = 1'b1;
            tick();
            bus.rd = 1'b0;
        end
        checks++;
        if (bus.empty !== 1'b1 || exp_q.size() != 0)
            $display("FAIL %s_drained empty=%b left_in_model=%0d expected empty=1 model=0", tag, bus.empty, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.level !== 5'd0)
            $display("FAIL reset_flags empty=%b full=%b level=%0d expected 1 0 0", bus.empty, bus.full, bus.level);
        else passed++;
        checks++;
        if (bus.ovf !== 1'b0 || bus.irq !== 1'b0 || bus.rd_data !== 32'h0)
            $display("FAIL reset_status ovf=%b irq=%b rd_data=%h expected 0 0 0", bus.ovf, bus.irq, bus.rd_data);
        else passed++;
    endtask

    task automatic test_stereo_sext();
        bus.stereo = 1'b1; bus.decim = 4'd0; bus.sign_ext = 1'b1; bus.en = 1'b1;
        tick();
        send_frame(32'h0080_0001, 32'h007F_FFFF);
        checks++;
        if (bus.level !== 5'd0) $display("FAIL arm_discard level=%0d expected 0", bus.level);
        else passed++;
        frame_open(32'h0080_0001, 32'h007F_FFFF);
        exp_q.push_back(32'hFF80_0001);
        exp_q.push_back(32'h007F_FFFF);
        tick(); tick();
        checks++;
        if (bus.level !== 5'd1 || bus.rd_data !== 32'hFF80_0001)
            $display("FAIL left_latency level=%0d rd_data=%h expected 1 ff800001", bus.level, bus.rd_data);
        else passed++;
        tick();
        checks++;
        if (bus.level !== 5'd2) $display("FAIL right_push level=%0d expected 2", bus.level);
        else passed++;
        tick();
        send_frame(32'h0080_0001, 32'h007F_FFFF);
        exp_q.push_back(32'hFF80_0001);
        exp_q.push_back(32'h007F_FFFF);
        checks++;
        if (bus.level !== 5'd4) $display("FAIL stereo_level level=%0d expected 4", bus.level);
        else passed++;
        bus.en = 1'b0;
        tick();
        drain("stereo");
    endtask

    task automatic test_mono_decim();
        bus.stereo = 1'b0; bus.decim = 4'd2; bus.sign_ext = 1'b0; bus.en = 1'b1;
        tick();
        send_frame(32'h0, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            logic [31:0] l;
            l = 32'hA580_0000 + i;
            if (i % 3 == 1) exp_q.push_back({8'h00, l[23:0]});
            send_frame(l, 32'hDEAD_0000 + i);
        end
        checks++;
        if (bus.level !== 5'd3) $display("FAIL decim_level level=%0d expected 3", bus.level);
        else passed++;
        bus.en = 1'b0;
        tick();
        drain("decim");
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        bus.stereo = 1'b1; bus.decim = 4'd0; bus.sign_ext = 1'b0; bus.en = 1'b1;
        tick();
        send_frame(32'h0, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) begin
                exp_q.push_back(32'h0011_0000 + i);
                exp_q.push_back(32'h0022_0000 + i);
            end
            send_frame(32'h0011_0000 + i, 32'h0022_0000 + i);
        end
        checks++;
        if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.ovf !== 1'b1)
            $display("FAIL ovf_fill level=%0d full=%b ovf=%b expected 16 1 1", bus.level, bus.full, bus.ovf);
        else passed++;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.ovf !== 1'b0 || bus.level !== 5'd16)
            $display("FAIL ovf_clr ovf=%b level=%0d expected 0 16", bus.ovf, bus.level);
        else passed++;
        bus.stereo = 1'b0;
        frame_open(32'h0033_0000, 32'h0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== e) $display("FAIL full_pop_head rd_data=%h expected %h", bus.rd_data, e);
        else passed++;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        exp_q.push_back(32'h0033_0000);
        checks++;
        if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.ovf !== 1'b0)
            $display("FAIL full_push_pop level=%0d full=%b ovf=%b expected 16 1 0", bus.level, bus.full, bus.ovf);
        else passed++;
        tick(); tick();
        bus.en = 1'b0;
        tick();
        drain("ovf");
    endtask

    task automatic test_irq();
        logic [31:0] e;
        bus.thresh = 5'd4; bus.stereo = 1'b0; bus.decim = 4'd0; bus.sign_ext = 1'b0; bus.en = 1'b1;
        tick();
        send_frame(32'h0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            logic [4:0] lv;
            logic       ei;
            exp_q.push_back(32'h0005_0000 + k);
            frame_open(32'h0005_0000 + k, 32'h0);
            tick();
            lv = 5'(k - 1);
            checks++;
            if (bus.level !== lv || bus.irq !== 1'b0)
                $display("FAIL irq_before level=%0d irq=%b expected %0d 0", bus.level, bus.irq, lv);
            else passed++;
            tick();
            lv = 5'(k);
            ei = (k >= 4) ? 1'b1 : 1'b0;
            checks++;
            if (bus.level !== lv || bus.irq !== ei)
                $display("FAIL irq_after level=%0d irq=%b expected %0d %b", bus.level, bus.irq, lv, ei);
            else passed++;
            tick(); tick();
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== e) $display("FAIL irq_pop_head rd_data=%h expected %h", bus.rd_data, e);
        else passed++;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        checks++;
        if (bus.level !== 5'd3 || bus.irq !== 1'b0)
            $display("FAIL irq_drop level=%0d irq=%b expected 3 0", bus.level, bus.irq);
        else passed++;
        bus.thresh = 5'd0;
        for (int k = 5; k <= 6; k++) begin
            exp_q.push_back(32'h0005_0000 + k);
            send_frame(32'h0005_0000 + k, 32'h0);
            checks++;
            if (bus.irq !== 1'b0) $display("FAIL irq_disabled irq=%b expected 0", bus.irq);
            else passed++;
        end
        checks++;
        if (bus.level !== 5'd5) $display("FAIL irq_level level=%0d expected 5", bus.level);
        else passed++;
        bus.en = 1'b0;
        tick();
        drain("irq");
    endtask

    task automatic test_en_abort();
        bus.stereo = 1'b1; bus.decim = 4'd0; bus.sign_ext = 1'b0; bus.en = 1'b1;
        tick();
        send_frame(32'h0, 32'h0);
        frame_open(32'h0044_0001, 32'h0044_0002);
        exp_q.push_back(32'h0044_0001);
        tick(); tick();
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.level !== 5'd1) $display("FAIL abort_right level=%0d expected 1", bus.level);
        else passed++;
        tick(); tick();
        bus.en = 1'b1;
        tick();
        send_frame(32'h0044_0003, 32'h0044_0004);
        checks++;
        if (bus.level !== 5'd1) $display("FAIL rearm_discard level=%0d expected 1", bus.level);
        else passed++;
        send_frame(32'h0044_0005, 32'h0044_0006);
        exp_q.push_back(32'h0044_0005);
        exp_q.push_back(32'h0044_0006);
        checks++;
        if (bus.level !== 5'd3) $display("FAIL rearm_push level=%0d expected 3", bus.level);
        else passed++;
        bus.en = 1'b0;
        tick();
        drain("abort");
    endtask

    task automatic test_flush();
        bus.stereo = 1'b1; bus.decim = 4'd0; bus.en = 1'b1;
        tick();
        send_frame(32'h0, 32'h0);
        send_frame(32'h0066_0001, 32'h0066_0002);
        send_frame(32'h0066_0003, 32'h0066_0004);
        frame_open(32'h0066_0005, 32'h0066_0006);
        tick(); tick();
        checks++;
        if (bus.level !== 5'd5) $display("FAIL flush_pre level=%0d expected 5", bus.level);
        else passed++;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.ovf !== 1'b0 || bus.rd_data !== 32'h0)
            $display("FAIL flush level=%0d empty=%b ovf=%b rd_data=%h expected 0 1 0 0",
                     bus.level, bus.empty, bus.ovf, bus.rd_data);
        else passed++;
        tick(); tick();
        checks++;
        if (bus.level !== 5'd0) $display("FAIL flush_hold level=%0d expected 0", bus.level);
        else passed++;
        bus.en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.thresh = 5'd1; bus.stereo = 1'b1; bus.decim = 4'd0; bus.en = 1'b1;
        tick();
        send_frame(32'h0, 32'h0);
        send_frame(32'h0077_0001, 32'h0077_0002);
        checks++;
        if (bus.level !== 5'd2 || bus.irq !== 1'b1)
            $display("FAIL rst_pre level=%0d irq=%b expected 2 1", bus.level, bus.irq);
        else passed++;
        frame_open(32'h0077_0003, 32'h0077_0004);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.ovf !== 1'b0 || bus.irq !== 1'b0 || bus.rd_data !== 32'h0)
            $display("FAIL async_reset level=%0d empty=%b full=%b ovf=%b irq=%b rd_data=%h expected 0 1 0 0 0 0",
                     bus.level, bus.empty, bus.full, bus.ovf, bus.irq, bus.rd_data);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(32'h0077_0005, 32'h0077_0006);
        checks++;
        if (bus.level !== 5'd0) $display("FAIL post_rst_discard level=%0d expected 0", bus.level);
        else passed++;
        send_frame(32'h0077_0007, 32'h0077_0008);
        exp_q.push_back(32'h0077_0007);
        exp_q.push_back(32'h0077_0008);
        checks++;
        if (bus.level !== 5'd2) $display("FAIL post_rst_push level=%0d expected 2", bus.level);
        else passed++;
        bus.en = 1'b0;
        bus.thresh = 5'd0;
        tick();
        drain("post_rst");
    endtask

    initial begin
        bus.en = 1'b0; bus.stereo = 1'b0; bus.sign_ext = 1'b0; bus.decim = 4'd0;
        bus.thresh = 5'd0; bus.flush = 1'b0; bus.ovf_clr = 1'b0; bus.rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_stereo_sext();
        test_mono_decim();
        test_overflow();
        test_irq();
        test_en_abort();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
